// File: rtl/mem_arb_pkg.sv
// Shared encodings for the Y86 memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic GRANT_F = 1'b0;
    localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/mux2.sv
// Generic N-bit 2-to-1 mux: y = s ? d1 : d0.
// Latency: purely combinational.
// Backpressure: none.
module mux2 #(
    parameter int N = 32
) (
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic         s,
    output logic [N-1:0] y
);

    assign y = s ? d1 : d0;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (F) and data (D); round-robin on ties, watchdog abort.
// Latency: grant one cycle after request; ack/err returned combinationally with mem_ack/timeout.
// Backpressure: requesters hold req until their ack/err; one memory transaction in flight.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = 15
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          f_req,
    input  logic [AW-1:0] f_addr,
    output logic          f_ack,
    output logic          f_err,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_ack,
    output logic          d_err,
    output logic [DW-1:0] rdata,
    output logic          sel,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_WAIT);

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] wait_cnt_q, wait_cnt_d;

    logic          go;
    logic          go_sel;
    logic          timeout;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            sel_q        <= GRANT_F;
            last_grant_q <= GRANT_F;
            wait_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
            wait_cnt_q   <= wait_cnt_d;
        end
    end

    assign timeout = (wait_cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        wait_cnt_d   = wait_cnt_q;
        go           = 1'b0;
        go_sel       = GRANT_F;
        f_ack        = 1'b0;
        f_err        = 1'b0;
        d_ack        = 1'b0;
        d_err        = 1'b0;

        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (f_req && d_req) begin
                    go     = 1'b1;
                    go_sel = (last_grant_q == GRANT_F) ? GRANT_D : GRANT_F;
                end else if (f_req || d_req) begin
                    go     = 1'b1;
                    go_sel = d_req ? GRANT_D : GRANT_F;
                end
            end
            BUSY_F: begin
                if (mem_ack) begin
                    f_ack        = 1'b1;
                    last_grant_d = GRANT_F;
                    // The acked requester sits out this arbitration round.
                    if (d_req) begin
                        go     = 1'b1;
                        go_sel = GRANT_D;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    f_err        = 1'b1;
                    last_grant_d = GRANT_F;
                    state_d      = IDLE;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            BUSY_D: begin
                if (mem_ack) begin
                    d_ack        = 1'b1;
                    last_grant_d = GRANT_D;
                    if (f_req) begin
                        go     = 1'b1;
                        go_sel = GRANT_F;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    d_err        = 1'b1;
                    last_grant_d = GRANT_D;
                    state_d      = IDLE;
                end else if (wait_cnt_q != CNT_MAX) begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (go) begin
            state_d    = (go_sel == GRANT_D) ? BUSY_D : BUSY_F;
            sel_d      = go_sel;
            wait_cnt_d = '0;
        end
    end

    assign sel       = sel_q;
    assign mem_req   = (state_q != IDLE);
    assign mem_we    = d_we & (state_q == BUSY_D);
    assign mem_wdata = (state_q == BUSY_D) ? d_wdata : '0;
    assign rdata     = mem_rdata;

    mux2 #(
        .N (AW)
    ) u_addr_mux (
        .d0 (f_addr),
        .d1 (d_addr),
        .s  (sel_q),
        .y  (mem_addr)
    );

endmodule
